gpio_serial_loader: RTL and testbench



---
 rtl/gpio_serial_loader.sv | 133 +++++++++++++
 tb/tb_gpio_serial_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
// Serial configuration sequencer for the user-area GPIO pad chain: fetches one
// config word per pad (farthest pad first), shifts it out MSB first, then strobes load.
module gpio_serial_loader #(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2,
  parameter int AW       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                start,
  input  logic                abort,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                busy,
  output logic                done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, FIN} state_t;

  state_t              state;
  logic [CFG_BITS-1:0] shreg;
  logic [BW-1:0]       bit_cnt;
  logic [DW-1:0]       div_cnt;
  logic                fetch_phase;
  logic                div_last;

  // serial_data is the shift register MSB itself, so it only moves when shreg does
  assign serial_data = shreg[CFG_BITS-1];
  assign div_last    = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      fetch_phase  <= 1'b0;
      cfg_addr     <= '0;
      serial_clock <= 1'b0;
      serial_load  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state       <= FETCH;
            cfg_addr    <= AW'(NUM_PADS - 1);
            busy        <= 1'b1;
            fetch_phase <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          if (abort) begin
            // partially shifted chain is left untouched; pads keep their latched config
            state        <= IDLE;
            busy         <= 1'b0;
            serial_clock <= 1'b0;
            serial_load  <= 1'b0;
          end else begin
            case (state)
              FETCH: begin
                if (!fetch_phase) begin
                  fetch_phase <= 1'b1;
                end else begin
                  shreg   <= cfg_data;
                  bit_cnt <= BW'(CFG_BITS - 1);
                  div_cnt <= '0;
                  state   <= SHIFT_LO;
                end
              end
              SHIFT_LO: begin
                if (div_last) begin
                  div_cnt      <= '0;
                  serial_clock <= 1'b1;
                  state        <= SHIFT_HI;
                end else begin
                  div_cnt <= div_cnt + DW'(1);
                end
              end
              SHIFT_HI: begin
                if (div_last) begin
                  div_cnt      <= '0;
                  serial_clock <= 1'b0;
                  shreg        <= shreg << 1;
                  if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - BW'(1);
                    state   <= SHIFT_LO;
                  end else if (cfg_addr != '0) begin
                    cfg_addr    <= cfg_addr - AW'(1);
                    fetch_phase <= 1'b0;
                    state       <= FETCH;
                  end else begin
                    serial_load <= 1'b1;
                    state       <= LOAD;
                  end
                end else begin
                  div_cnt <= div_cnt + DW'(1);
                end
              end
              LOAD: begin
                if (div_last) begin
                  div_cnt     <= '0;
                  serial_load <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= FIN;
                end else begin
                  div_cnt <= div_cnt + DW'(1);
                end
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: a pad-chain model (shift on serial_clock rise, latch on
// serial_load) is compared against the config words the bench placed in its array.
`timescale 1ns/1ps
module tb_gpio_serial_loader;
  localparam int NP        = 19;
  localparam int CB        = 13;
  localparam int CD        = 2;
  localparam int AW        = $clog2(NP);
  localparam int EXP_BUSY  = NP * (2 + 2 * CD * CB) + CD;
  localparam int EXP_BUSY2 = 1 * (2 + 2 * 1 * CB) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetb, start, abort;
  logic [AW-1:0] cfg_addr;
  logic [CB-1:0] cfg_data;
  logic          serial_clock, serial_data, serial_load, busy, done;

  logic          start2, abort2;
  logic [0:0]    cfg_addr2;
  logic [CB-1:0] cfg_data2;
  logic          sclk2, sdat2, sload2, busy2, done2;

  gpio_serial_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(CD)) dut (
    .clock(clk), .resetb(resetb), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .serial_clock(serial_clock), .serial_data(serial_data), .serial_load(serial_load),
    .busy(busy), .done(done)
  );

  gpio_serial_loader #(.NUM_PADS(1), .CFG_BITS(CB), .CLK_DIV(1)) dut2 (
    .clock(clk), .resetb(resetb), .start(start2), .abort(abort2),
    .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
    .serial_clock(sclk2), .serial_data(sdat2), .serial_load(sload2),
    .busy(busy2), .done(done2)
  );

  // Housekeeping config array with a one-cycle registered read
  logic [CB-1:0] mem [NP];
  logic [CB-1:0] mem_prev [NP];
  logic [CB-1:0] word2;
  always @(posedge clk) cfg_data  <= mem[cfg_addr];
  always @(posedge clk) cfg_data2 <= (cfg_addr2 == 1'b0) ? word2 : '0;

  // Pad chain model and event counters for the main instance
  int              rise_cnt = 0, load_cnt = 0, done_cnt = 0, busy_cycles = 0, viol_cnt = 0;
  logic [NP*CB-1:0] chain = '0;
  logic [CB-1:0]    latch [NP];
  int               addr_log[$];
  logic prev_sclk = 1'b0, prev_sload = 1'b0, prev_sdat = 1'b0, prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (serial_clock === 1'b1 && prev_sclk === 1'b0) begin
      rise_cnt++;
      chain = {chain[NP*CB-2:0], serial_data};
    end
    if (serial_load === 1'b1 && prev_sload === 1'b0) begin
      load_cnt++;
      for (int i = 0; i < NP; i++) latch[i] = chain[i*CB +: CB];
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cycles++;
    if (serial_clock === 1'b1 && serial_load === 1'b1) viol_cnt++;
    if (serial_clock === 1'b1 && serial_data !== prev_sdat) viol_cnt++;
    if (busy === 1'b1 && (prev_busy !== 1'b1 || cfg_addr != prev_addr)) addr_log.push_back(int'(cfg_addr));
    prev_sclk  = serial_clock;
    prev_sload = serial_load;
    prev_sdat  = serial_data;
    prev_busy  = busy;
    prev_addr  = cfg_addr;
  end

  // Bit stream recorder for the single-pad instance
  int   cyc = 0, busy2_cycles = 0, done2_cnt = 0, load2_cnt = 0;
  int   rise_times[$];
  logic stream2[$];
  logic p_sclk2 = 1'b0, p_sload2 = 1'b0, p_sdat2 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (sclk2 === 1'b1 && p_sclk2 === 1'b0) begin
      rise_times.push_back(cyc);
      stream2.push_back(sdat2);
    end
    if (sload2 === 1'b1 && p_sload2 === 1'b0) load2_cnt++;
    if (done2 === 1'b1) done2_cnt++;
    if (busy2 === 1'b1) busy2_cycles++;
    if (sclk2 === 1'b1 && sload2 === 1'b1) viol_cnt++;
    if (sclk2 === 1'b1 && sdat2 !== p_sdat2) viol_cnt++;
    p_sclk2  = sclk2;
    p_sload2 = sload2;
    p_sdat2  = sdat2;
  end

  int n_checks = 0, n_pass = 0;
  int b_rise, b_load, b_done, b_busy, b_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_rise = rise_cnt;
    b_load = load_cnt;
    b_done = done_cnt;
    b_busy = busy_cycles;
    b_addr = addr_log.size();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NP; i++) mem[i] = CB'($urandom);
  endtask

  task automatic check_idle_outputs(input string t);
    check({t, "_busy"},     32'(busy),         32'd0);
    check({t, "_done"},     32'(done),         32'd0);
    check({t, "_sclk"},     32'(serial_clock), 32'd0);
    check({t, "_sdata"},    32'(serial_data),  32'd0);
    check({t, "_sload"},    32'(serial_load),  32'd0);
    check({t, "_cfg_addr"}, 32'(cfg_addr),     32'd0);
  endtask

  // Pulse start, optionally re-pulse it at two cycle offsets, wait (bounded) for done
  task automatic run_load(input int re1, input int re2);
    bit ok;
    ok = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int c = 1; c < 3000 && !ok; c++) begin
      if (c == re1 || c == re2) start = 1'b1;
      step(1);
      start = 1'b0;
      if (done === 1'b1) ok = 1'b1;
    end
    check("done_seen", 32'(ok), 32'd1);
    step(3);
  endtask

  task automatic check_full_load(input string t);
    check({t, "_busy_len"}, 32'(busy_cycles - b_busy), 32'(EXP_BUSY));
    check({t, "_rises"},    32'(rise_cnt - b_rise),    32'(NP * CB));
    check({t, "_loads"},    32'(load_cnt - b_load),    32'd1);
    check({t, "_dones"},    32'(done_cnt - b_done),    32'd1);
    check({t, "_addr_cnt"}, 32'(addr_log.size() - b_addr), 32'(NP));
    for (int k = 0; k < NP; k++)
      check($sformatf("%s_addr%0d", t, k), 32'(addr_log[b_addr + k]), 32'(NP - 1 - k));
    for (int i = 0; i < NP; i++)
      check($sformatf("%s_pad%0d", t, i), 32'(latch[i]), 32'(mem[i]));
  endtask

  task automatic run_dut2(input logic [CB-1:0] w, input string t);
    int  base, bb, bd, bl;
    bit  ok;
    word2 = w;
    base  = stream2.size();
    bb    = busy2_cycles;
    bd    = done2_cnt;
    bl    = load2_cnt;
    ok    = 1'b0;
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      step(1);
      if (done2 === 1'b1) ok = 1'b1;
    end
    check({t, "_done_seen"}, 32'(ok), 32'd1);
    step(3);
    check({t, "_busy_len"}, 32'(busy2_cycles - bb), 32'(EXP_BUSY2));
    check({t, "_bits"},     32'(stream2.size() - base), 32'(CB));
    check({t, "_loads"},    32'(load2_cnt - bl), 32'd1);
    check({t, "_dones"},    32'(done2_cnt - bd), 32'd1);
    for (int k = 0; k < CB; k++)
      check($sformatf("%s_bit%0d", t, k), 32'(stream2[base + k]), 32'((w >> (CB - 1 - k)) & 1));
    for (int k = 0; k < CB - 1; k++)
      check($sformatf("%s_period%0d", t, k), 32'(rise_times[base + k + 1] - rise_times[base + k]), 32'd2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetb = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    word2  = '0;
    for (int i = 0; i < NP; i++) mem[i] = '0;
    step(2);
    check_idle_outputs("reset");
    resetb = 1'b1;
    step(2);

    // Full load with the recognisable pattern, then two random arrays
    for (int i = 0; i < NP; i++) mem[i] = CB'(32'h1000 | i);
    snap();
    run_load(-1, -1);
    check_full_load("t1");
    for (int r = 0; r < 2; r++) begin
      randomize_mem();
      snap();
      run_load(-1, -1);
      check_full_load($sformatf("rand%0d", r));
    end

    // Single pad, divider 1
    run_dut2(13'h1A5B, "t2");
    run_dut2(CB'($urandom), "t2r");

    // Abort after 100 busy cycles: chain latches keep the previous config
    for (int i = 0; i < NP; i++) mem_prev[i] = mem[i];
    randomize_mem();
    snap();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(99);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t3_busy",  32'(busy),         32'd0);
    check("t3_sclk",  32'(serial_clock), 32'd0);
    check("t3_sload", 32'(serial_load),  32'd0);
    step(20);
    check("t3_busy_len", 32'(busy_cycles - b_busy), 32'd100);
    check("t3_loads",    32'(load_cnt - b_load),    32'd0);
    check("t3_dones",    32'(done_cnt - b_done),    32'd0);
    for (int i = 0; i < NP; i++)
      check($sformatf("t3_pad%0d", i), 32'(latch[i]), 32'(mem_prev[i]));

    // Start re-pulsed mid-load is ignored
    randomize_mem();
    snap();
    run_load(10, 500);
    check_full_load("t4");

    // Asynchronous reset while serial_clock is high
    randomize_mem();
    snap();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(300);
    for (int i = 0; i < 8 && serial_clock !== 1'b1; i++) step(1);
    check("t5_in_shift_hi", 32'(serial_clock), 32'd1);
    #2;
    resetb = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    step(2);
    check("t5_busy_held", 32'(busy), 32'd0);
    resetb = 1'b1;
    step(2);
    check("t5_loads", 32'(load_cnt - b_load), 32'd0);
    check("t5_dones", 32'(done_cnt - b_done), 32'd0);
    randomize_mem();
    snap();
    run_load(-1, -1);
    check_full_load("t5");

    // start and abort together in IDLE: nothing happens
    snap();
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    step(20);
    check("t6_busy_len", 32'(busy_cycles - b_busy), 32'd0);
    check("t6_rises",    32'(rise_cnt - b_rise),    32'd0);
    check("t6_dones",    32'(done_cnt - b_done),    32'd0);

    check("clk_load_overlap_or_data_move_while_high", 32'(viol_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
